// File: rtl/rv32_ahb_pkg.sv
// AHB-Lite encodings and arbiter state enum shared by the rv32 bus-master slice.
package rv32_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_ERR
  } arb_state_e;

endpackage

// File: rtl/ahb_arb_grant.sv
// Two-way grant picker: D-side (bit1) wins ties, or alternates ties when
// AHB_ARB_ROUND_ROBIN_EN is defined.
module ahb_arb_grant (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic last_served;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_served <= 1'b0;
    else if (take)
      last_served <= gnt;
  end

  // last_served resets to I-side so the first tie still goes to D-side
  always_comb begin
    gnt = req[1];
    if (req == 2'b11)
      gnt = ~last_served;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, reset, take};
  assign gnt       = req[1];
`endif

endmodule

// File: rtl/ahb_master_arbiter.sv
// Arbitrates I-cache and D-cache refill engines onto one AHB-Lite master port
// as pipelined INCR word bursts. Round-robin ties: AHB_ARB_ROUND_ROBIN_EN.
module ahb_master_arbiter
  import rv32_ahb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 8,
  parameter int LEN_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          m_req,
  input  logic [2*ADDR_W-1:0] m_addr,
  input  logic [1:0]          m_write,
  input  logic [2*LEN_W-1:0]  m_len,
  input  logic [2*DATA_W-1:0] m_wdata,
  output logic [1:0]          m_wnext,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          m_rvalid,
  output logic [1:0]          m_done,
  output logic [1:0]          m_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   HADDR,
  output logic [1:0]          HTRANS,
  output logic [2:0]          HBURST,
  output logic [2:0]          HSIZE,
  output logic [3:0]          HPROT,
  output logic                HMASTLOCK,
  output logic                HWRITE,
  output logic [DATA_W-1:0]   HWDATA,
  input  logic [DATA_W-1:0]   HRDATA,
  input  logic                HREADY,
  input  logic                HRESP
);

  // state  | meaning
  // IDLE   | waiting for a request; grant taken here
  // ADDR   | NONSEQ address phase on the bus
  // BURST  | SEQ address phases still to issue
  // LAST   | all addresses issued, draining final data phase
  // ERR    | error response seen, waiting for its second cycle

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  arb_state_e       state, state_d;
  logic             gnt, take, owner, dp_valid, htrans_active;
  logic             addr_acc, beat_ok, beat_last, bus_err, more;
  logic [LEN_W-1:0] raw_len;
  logic [CNT_W-1:0] req_len, len_q, issued, completed;
  logic [2:0]       req_burst;

  ahb_arb_grant u_grant (
    .clk   (clk),
    .reset (reset),
    .req   (m_req),
    .take  (take),
    .gnt   (gnt)
  );

  assign HSIZE     = HSIZE_WORD;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    htrans_active = (HTRANS != HTRANS_IDLE) && (HTRANS != HTRANS_BUSY);
    addr_acc      = htrans_active && HREADY;
    beat_ok       = dp_valid && HREADY && !HRESP;
    beat_last     = beat_ok && ((completed + 1'b1) == len_q);
    bus_err       = dp_valid && !HREADY && HRESP;
    more          = (issued + 1'b1) < len_q;

    raw_len = gnt ? m_len[2*LEN_W-1:LEN_W] : m_len[LEN_W-1:0];
    if (raw_len == '0)
      req_len = CNT_W'(1);
    else if (int'(raw_len) > MAX_BEATS)
      req_len = CNT_W'(MAX_BEATS);
    else
      req_len = CNT_W'(raw_len);

    if (req_len == CNT_W'(1))
      req_burst = HBURST_SINGLE;
    else if (req_len == CNT_W'(4))
      req_burst = HBURST_INCR4;
    else if (req_len == CNT_W'(8))
      req_burst = HBURST_INCR8;
    else
      req_burst = HBURST_INCR;
  end

  always_comb begin
    state_d = state;
    take    = 1'b0;
    case (state)
      ST_IDLE: if (|m_req) begin
        take    = 1'b1;
        state_d = ST_ADDR;
      end
      ST_ADDR, ST_BURST: begin
        if (bus_err)
          state_d = ST_ERR;
        else if (addr_acc)
          state_d = more ? ST_BURST : ST_LAST;
      end
      ST_LAST: begin
        if (bus_err)
          state_d = ST_ERR;
        else if (beat_last)
          state_d = ST_IDLE;
      end
      ST_ERR:  if (HREADY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HBURST    <= HBURST_SINGLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      owner     <= 1'b0;
      len_q     <= '0;
      issued    <= '0;
      completed <= '0;
      dp_valid  <= 1'b0;
      m_rdata   <= '0;
      m_rvalid  <= '0;
      m_wnext   <= '0;
      m_done    <= '0;
      m_err     <= '0;
    end else begin
      m_rvalid <= '0;
      m_wnext  <= '0;
      m_done   <= '0;
      m_err    <= '0;

      if (take) begin
        owner     <= gnt;
        len_q     <= req_len;
        issued    <= '0;
        completed <= '0;
        HADDR     <= gnt ? m_addr[2*ADDR_W-1:ADDR_W] : m_addr[ADDR_W-1:0];
        HTRANS    <= HTRANS_NONSEQ;
        HBURST    <= req_burst;
        HWRITE    <= m_write[gnt];
      end

      // an error cancels whatever address phase is pending
      if (bus_err) begin
        HTRANS <= HTRANS_IDLE;
      end else if (addr_acc) begin
        issued <= issued + 1'b1;
        if (HWRITE) begin
          HWDATA         <= owner ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
          m_wnext[owner] <= 1'b1;
        end
        if (more) begin
          HTRANS <= HTRANS_SEQ;
          HADDR  <= HADDR + ADDR_W'(4);
        end else begin
          HTRANS <= HTRANS_IDLE;
        end
      end

      if (HREADY)
        dp_valid <= htrans_active;

      if (beat_ok) begin
        completed <= completed + 1'b1;
        if (!HWRITE) begin
          m_rdata         <= HRDATA;
          m_rvalid[owner] <= 1'b1;
        end
        if (beat_last)
          m_done[owner] <= 1'b1;
      end

      if (state == ST_ERR && HREADY)
        m_err[owner] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with a small AHB slave that can insert
// wait states or a two-cycle error on a chosen beat.
module tb_ahb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_req, m_write;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_len;
  logic [1:0]  m_wnext, m_rvalid, m_done, m_err;
  logic [31:0] m_rdata, HADDR, HWDATA, HRDATA;
  logic        busy, HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;

  ahb_master_arbiter dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_write(m_write),
    .m_len(m_len), .m_wdata(m_wdata), .m_wnext(m_wnext), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .m_done(m_done), .m_err(m_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // slave / monitor state
  int          beat, stall, err_beat, wait_beat, wait_n, widx;
  bit          dp, erst, perr, prev_ready, prev_act;
  logic [31:0] dp_addr, prev_addr;
  int          rv_cnt[2], wn_cnt[2], dn_cnt[2], er_cnt[2];
  logic [31:0] rdata_q[$], acc_q[$], hw_q[$], stall_q[$];
  logic [1:0]  stallt_q[$], errt_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rdata_q.delete(); acc_q.delete(); hw_q.delete();
    stall_q.delete(); stallt_q.delete(); errt_q.delete();
    for (int i = 0; i < 2; i++) begin
      rv_cnt[i] = 0; wn_cnt[i] = 0; dn_cnt[i] = 0; er_cnt[i] = 0;
    end
    beat = 0; err_beat = -1; wait_beat = -1; wait_n = 0; widx = 0;
  endtask

  // slave model and monitor, all decisions taken on the falling edge
  initial begin
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; m_wdata = '0;
    dp = 0; erst = 0; perr = 0; prev_ready = 1; prev_act = 0; prev_addr = '0;
    dp_addr = '0; stall = 0;
    clr();
    forever begin
      @(negedge clk);
      if (reset) begin
        dp = 0; prev_ready = 1; prev_act = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_rvalid[i]) rv_cnt[i]++;
          if (m_wnext[i])  wn_cnt[i]++;
          if (m_done[i])   dn_cnt[i]++;
          if (m_err[i])    er_cnt[i]++;
        end
        if (m_rvalid != 2'b00) rdata_q.push_back(m_rdata);
        if (m_wnext[1]) widx++;
        m_wdata = {32'hA0 + widx, 32'h0000_0055};
        if (prev_ready) begin
          if (prev_act) begin
            acc_q.push_back(prev_addr);
            dp = 1; dp_addr = prev_addr; erst = 0;
            stall = (beat == wait_beat) ? wait_n : 0;
            perr = (beat == err_beat);
            beat++;
          end else begin
            dp = 0;
          end
        end
        HREADY = 1'b1; HRESP = 1'b0;
        if (dp) begin
          if (perr) begin
            HRESP = 1'b1; HREADY = erst;
            if (erst) errt_q.push_back(HTRANS);
            erst = 1;
          end else if (stall > 0) begin
            HREADY = 1'b0; stall--;
            stall_q.push_back(HADDR); stallt_q.push_back(HTRANS);
          end else begin
            hw_q.push_back(HWDATA);
          end
        end
        HRDATA = dp ? dp_addr + 32'h1000_0000 : 32'h0;
        prev_ready = HREADY;
        prev_act   = HTRANS[1];
        prev_addr  = HADDR;
      end
    end
  end

  task automatic run(input int m, input logic [31:0] addr, input int len, input bit wr,
                     input logic [2:0] exp_burst, output int cycles, output bit got_err);
    m_addr[m*32 +: 32] = addr;
    m_len[m*4 +: 4]    = len[3:0];
    m_write[m]         = wr;
    m_req[m]           = 1'b1;
    @(negedge clk);
    chk("first_nonseq", HTRANS, 2'b10);
    chk("first_haddr", HADDR, addr);
    chk("hburst", HBURST, exp_burst);
    chk("hwrite", HWRITE, wr);
    chk("busy", busy, 1'b1);
    cycles = 1;
    while (!m_done[m] && !m_err[m] && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    chk("completion_timeout", cycles >= 200, 0);
    got_err = m_err[m];
    if (!got_err) chk("done_with_rvalid", m_rvalid[m], !wr);
    m_req[m] = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_burst(input int m, input logic [31:0] base, input int n, input bit wr);
    chk("accepted_count", acc_q.size(), n);
    for (int i = 0; i < n; i++) begin
      chk("beat_haddr", (i < acc_q.size()) ? acc_q[i] : 'x, base + 32'(4 * i));
      if (wr) chk("beat_hwdata", (i < hw_q.size()) ? hw_q[i] : 'x, 32'hA0 + 32'(i));
      else    chk("beat_rdata", (i < rdata_q.size()) ? rdata_q[i] : 'x,
                  base + 32'(4 * i) + 32'h1000_0000);
    end
    chk("rvalid_count", rv_cnt[m], wr ? 0 : n);
    chk("wnext_count", wn_cnt[m], wr ? n : 0);
    chk("done_count", dn_cnt[m], 1);
    chk("other_master_quiet", rv_cnt[1-m] + dn_cnt[1-m] + wn_cnt[1-m], 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int cyc, cnt;
  bit e;
  int order[$];
`ifdef AHB_ARB_ROUND_ROBIN_EN
  int exp_b[4] = '{1, 0, 1, 0};
`else
  int exp_b[4] = '{1, 1, 1, 1};
`endif

  initial begin
    reset = 1'b1; m_req = '0; m_write = '0; m_addr = '0; m_len = '0;
    repeat (2) @(negedge clk);
    chk("reset_ahb", {HTRANS, HBURST, HSIZE, HPROT, HMASTLOCK, HWRITE},
        {2'b00, 3'b000, 3'b010, 4'b0011, 1'b0, 1'b0});
    chk("reset_haddr_hwdata", {HADDR, HWDATA}, 64'h0);
    chk("reset_m_outs", {m_wnext, m_rvalid, m_done, m_err, busy}, 9'h0);
    reset = 1'b0;
    @(negedge clk);

    // D-side read, 8 beats, zero wait
    clr();
    run(1, 32'h100, 8, 0, 3'b101, cyc, e);
    chk("d_read8_cycles", cyc, 10);
    chk("d_read8_err", e, 0);
    check_burst(1, 32'h100, 8, 0);

    // I-side read, 4 beats, 2 waits on the second data phase
    clr(); wait_beat = 1; wait_n = 2;
    run(0, 32'h200, 4, 0, 3'b011, cyc, e);
    chk("i_read4_cycles", cyc, 8);
    check_burst(0, 32'h200, 4, 0);
    chk("stall_count", stall_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      chk("stall_haddr_hold", (i < stall_q.size()) ? stall_q[i] : 'x, 32'h208);
      chk("stall_htrans_hold", (i < stallt_q.size()) ? stallt_q[i] : 'x, 2'b11);
    end

    // D-side write, 4 beats 0xA0..0xA3
    clr();
    run(1, 32'h300, 4, 1, 3'b011, cyc, e);
    chk("d_write4_cycles", cyc, 6);
    check_burst(1, 32'h300, 4, 1);

    // length edge cases: 0 -> 1 beat, 12 -> clamped to 8, 3 -> INCR
    clr();
    run(0, 32'h400, 0, 0, 3'b000, cyc, e);
    chk("len0_cycles", cyc, 3);
    check_burst(0, 32'h400, 1, 0);
    clr();
    run(1, 32'h500, 12, 0, 3'b101, cyc, e);
    chk("len12_cycles", cyc, 10);
    check_burst(1, 32'h500, 8, 0);
    clr();
    run(0, 32'h600, 3, 0, 3'b001, cyc, e);
    chk("len3_cycles", cyc, 5);
    check_burst(0, 32'h600, 3, 0);

    // error on the third data phase of an 8-beat read
    clr(); err_beat = 2;
    run(1, 32'h100, 8, 0, 3'b101, cyc, e);
    chk("err_seen", e, 1);
    chk("err_cycles", cyc, 6);
    repeat (2) @(negedge clk);
    chk("err_pulses", er_cnt[1], 1);
    chk("err_no_done", dn_cnt[1], 0);
    chk("err_rvalid_count", rv_cnt[1], 2);
    chk("err_accepted", acc_q.size(), 3);
    chk("err_next_htrans_logged", errt_q.size(), 1);
    chk("err_next_htrans_idle", (errt_q.size() > 0) ? errt_q[0] : 'x, 2'b00);
    chk("err_busy_clear", busy, 0);
    clr();
    run(0, 32'h700, 4, 0, 3'b011, cyc, e);
    chk("after_err_cycles", cyc, 6);
    check_burst(0, 32'h700, 4, 0);

    // reset in the middle of a burst
    clr();
    m_addr[63:32] = 32'h100; m_len[7:4] = 4'd8; m_write[1] = 1'b0; m_req[1] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_ahb", {HTRANS, HBURST, HWRITE, busy}, 7'h0);
    chk("midrst_haddr_hwdata", {HADDR, HWDATA}, 64'h0);
    chk("midrst_m_outs", {m_wnext, m_rvalid, m_done, m_err}, 8'h0);
    m_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_no_done_err", dn_cnt[1] + er_cnt[1], 0);
    clr();
    run(0, 32'h800, 1, 0, 3'b000, cyc, e);
    chk("post_reset_cycles", cyc, 3);
    check_burst(0, 32'h800, 1, 0);

    // ties: fresh reset, both masters request single-beat reads
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr();
    m_addr = {32'h900, 32'hA00}; m_len = {4'd1, 4'd1}; m_write = '0;
    m_req = 2'b11;
    @(negedge clk);
    chk("tie_first_haddr", HADDR, 32'h900);
    cnt = 0;
    while (order.size() < 2 && cnt < 100) begin
      for (int i = 0; i < 2; i++)
        if (m_done[i]) begin order.push_back(i); m_req[i] = 1'b0; end
      if (order.size() < 2) @(negedge clk);
      cnt++;
    end
    chk("tie_a_timeout", cnt >= 100, 0);
    chk("tie_a_first", (order.size() > 0) ? order[0] : -1, 1);
    chk("tie_a_second", (order.size() > 1) ? order[1] : -1, 0);

    order.delete();
    m_req = 2'b11;
    cnt = 0;
    while (order.size() < 4 && cnt < 200) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (m_done[i]) order.push_back(i);
      cnt++;
    end
    m_req = 2'b00;
    chk("tie_b_timeout", cnt >= 200, 0);
    for (int i = 0; i < 4; i++)
      chk("tie_b_order", (i < order.size()) ? order[i] : -1, exp_b[i]);
    cnt = 0;
    while (busy && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("tie_b_drain", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Sits between the core's instruction-cache (master 0) and data-cache (master 1) refill/writeback engines and the core's single AHB-Lite master port.
- Arbitrates the two requesters and runs each granted request as a pipelined incrementing word burst, overlapping address and data phases.
- Returns read beats and write-beat acknowledgements to the owner, then signals completion or error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed word transfers.
- MAX_BEATS, 8, maximum beats per request (32-byte line).
- LEN_W, 4, width of each per-master beat-count field.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
m_req  in  2  request per master (bit0 = I-side, bit1 = D-side); held high until m_done or m_err
m_addr  in  2*ADDR_W  word-aligned start address per master
m_write  in  2  1 = write burst
m_len  in  2*LEN_W  beat count 1..MAX_BEATS
m_wdata  in  2*DATA_W  current write beat; advanced by requester on m_wnext
m_wnext  out  2  pulse: current write beat captured
m_rdata  out  DATA_W  read beat, shared by both masters
m_rvalid  out  2  pulse: m_rdata valid for that master
m_done  out  2  pulse: final beat complete
m_err  out  2  pulse: burst aborted on HRESP error
busy  out  1  transfer in progress
HADDR  out  ADDR_W  AHB address
HTRANS  out  2  AHB transfer type
HBURST  out  3  AHB burst type
HSIZE  out  3  AHB size
HPROT  out  4  AHB protection
HMASTLOCK  out  1  AHB lock
HWRITE  out  1  AHB write
HWDATA  out  DATA_W  AHB write data
HRDATA  in  DATA_W  AHB read data
HREADY  in  1  AHB ready
HRESP  in  1  AHB error response

Behaviour:
- Reset (async):
  - HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HWRITE=0, HWDATA=0.
  - HSIZE=3'b010, HPROT=4'b0011, HMASTLOCK=0.
  - All m_* outputs and busy = 0; state IDLE.
  - Reset mid-burst abandons the burst with no done or err pulse.
- All AHB outputs are registered.
- States: IDLE, ADDR, BURST, LAST, ERR.
- IDLE:
  - Any m_req high → grant (D-side wins on a tie).
  - Latch owner, address, len and write.
  - Next cycle: HTRANS=NONSEQ, HADDR=start; go to ADDR.
  - Latency: request to first NONSEQ is 1 clock.
- m_len handling: 0 is treated as 1; values > MAX_BEATS are clamped to MAX_BEATS.
- HBURST encoding: len 1 → SINGLE; 4 → INCR4; 8 → INCR8; any other len → INCR.
- Address phase accepted (HTRANS active and HREADY=1):
  - Issue next beat as HTRANS=SEQ with HADDR+4 while beats remain.
  - After the last address phase, drive HTRANS=IDLE and go to LAST.
  - When more than one beat remains, state is BURST.
- While HREADY=0, HADDR, HTRANS, HBURST, HWRITE and HWDATA hold stable.
- Write beats: when an address phase is accepted, register HWDATA <= owner's m_wdata and pulse m_wnext[owner]. HWDATA is therefore valid throughout the matching data phase.
- Read beats: each data phase that completes with HREADY=1 and HRESP=0 registers m_rdata <= HRDATA and pulses m_rvalid[owner] one cycle later.
- Counters:
  - issued-beat and completed-beat counters, each width clog2(MAX_BEATS)+1.
  - The final completed beat pulses m_done[owner] in the same cycle as the last m_rvalid (reads) or one cycle after the last data phase (writes).
  - Then return to IDLE.
- Back-to-back requests: the next request may be granted in the cycle after m_done. No idle gap is required beyond the IDLE state cycle.
- Error (HRESP=1 with HREADY=0 during a data phase):
  - Next cycle force HTRANS=IDLE, cancelling any pending SEQ.
  - Enter ERR and wait for HREADY=1.
  - Then pulse m_err[owner] and go to IDLE.
  - Remaining beats are dropped; no m_done is issued.
- A requester dropping m_req mid-burst is illegal and is ignored; the burst completes.
- busy = 1 in every state except IDLE.

Optional Feature:
- Macro: AHB_ARB_ROUND_ROBIN_EN.
- Defined: on a tie, the grant goes to the master not served last. Last-served is a 1-bit register, reset to 0, so D-side wins the first tie after reset.
- Undefined: fixed priority, D-side always wins ties.

Decomposition:
- Shared package rv32_ahb_pkg holds:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST codes: SINGLE, INCR, INCR4, INCR8.
  - HSIZE_WORD and HPROT_DEFAULT constants.
  - State enum.
- One sub-module, ahb_arb_grant: a combinational 2-way priority / round-robin picker with a registered last-served bit.

Test Plan:
- D-side read, len 8 at 0x100, zero-wait slave:
  - NONSEQ at 0x100, then SEQ at 0x104 through 0x11C, HBURST=INCR8.
  - 8 m_rvalid[1] pulses, m_done[1] with the 8th pulse.
  - Total 10 clocks from m_req to m_done.
- I-side read, len 4; slave inserts 2 wait states on beat 2:
  - HADDR and HTRANS hold 0x208/SEQ during the waits.
  - Read data arrives in order; m_done[0] asserts.
- Both m_req raised in the same cycle:
  - Without the macro, D-side is served first, then I-side.
  - With AHB_ARB_ROUND_ROBIN_EN, repeated ties alternate grants 1, 0, 1, 0.
- D-side write, len 4, data 0xA0..0xA3:
  - HWDATA shows 0xA0..0xA3 in successive data phases.
  - 4 m_wnext pulses, HWRITE=1, m_done[1].
- HRESP error on beat 3 of an 8-beat read:
  - HTRANS goes IDLE in the next cycle; m_err pulses once; no m_done.
  - A following request proceeds normally.
- Reset asserted mid-burst:
  - All outputs return to reset values immediately.
  - The first NONSEQ is issued 1 clock after a post-reset request.
